a_row_skew_feeder: RTL and testbench
====================================

Name: a_row_skew_feeder

Overview:
- Sits directly downstream of the A-operand read address generator; consumes the BRAM read data returned for each issued A address, steered by the one-hot row-select that accompanies that address.
- Collects one N1-row x M2-column tile into a ping-pong row buffer, then streams it into the N1 west-edge rows of the systolic array with a triangular skew: row i is delayed i cycles.
- Loading of tile p+1 overlaps streaming of tile p.

Parameters:
N1, 4, systolic rows; lane count; width of the row-select one-hot
D_W, 8, element width
MATRIXSIZE_W, 16, width of the matrix dimension input
MAX_M2, 64, maximum inner dimension; per-row buffer depth per bank
RD_LAT, 2, BRAM read latency in cycles from address cycle to rd_data_A valid

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
M2  in  MATRIXSIZE_W  inner dimension, 1..MAX_M2; stable from first load until done
addr_vld_A  in  1  rd_addr_A/activate_A carry a valid address this cycle
activate_A  in  N1  one-hot target row for the address this cycle
last_addr_A  in  1  final address of the matrix; aligned with addr_vld_A
rd_data_A  in  D_W  BRAM data, valid RD_LAT cycles after its address cycle
ready_A  out  1  upstream may assert its read enable only while high
a_out  out  N1*D_W  lane i (bits i*D_W +: D_W) drives systolic row i
a_vld  out  N1  per-lane valid
a_ready  in  1  array advance enable; low stalls streaming
done  out  1  one-cycle pulse after the last tile has fully drained

Behaviour:
- Reset: all outputs 0, ready_A=1, both banks EMPTY, all pointers 0, delay line cleared. Mid-operation reset drops in-flight data; upstream is reset on the same cycle.
- Alignment: addr_vld_A, activate_A and last_addr_A pass through an RD_LAT-stage shift register. A write occurs when the delayed valid is high: rd_data_A goes to bank wb, row = delayed one-hot, column = wcol[row]. wcol[row] increments per write and wraps to 0 at M2-1.
- A delayed valid with activate not one-hot is a protocol error: no write; simulation assertion.
- Bank states: EMPTY -> LOADING (first write) -> FULL (write to row N1-1, column M2-1) -> STREAMING (stream side picks it up) -> EMPTY (after drain).
  - FULL transition toggles wb and clears wcol.
  - Delayed last_addr_A on that write tags the bank LAST.
- Issue-side credit: issue counter ic counts addr_vld_A up to N1*M2 per tile, toggling issue bank ib on wrap.
  - ready_A = (bank ib is EMPTY or LOADING) registered one cycle early, i.e. low the cycle after the final address of a tile if bank !ib is not yet EMPTY.
  - Upstream sees ready_A low before any address for an occupied bank, so no overwrite is possible.
- Stream FSM: IDLE -> RUN when the bank at rb is FULL.
  - RUN: skew counter k runs 0..M2+N1-2, advancing only when a_ready=1.
  - Lane i: a_vld[i] = (i <= k < i+M2); a_out lane = buf[rb][i][k-i]. Outputs are registered, 1-cycle latency from k.
  - At k = M2+N1-2 with a_ready: bank -> EMPTY, rb toggles, then IDLE, or directly RUN on the next bank if it is FULL. There is no bubble between tiles other than the skew drain.
  - a_ready=0: k, a_out and a_vld hold.
- done pulses the cycle after the LAST bank drains; the FSM returns to IDLE and the credit counters are at 0.
- Write and stream on the same bank in one cycle cannot occur; an assertion checks it.
- M2=1: the tile is a column; k runs 0..N1-1; each lane is valid for exactly one cycle.

Optional Feature:
- Macro A_ZERO_PAD_EN.
- Defined: lanes with a_vld[i]=0 drive a_out lane = 0, so the array may ignore a_vld and accumulate zeros safely.
- Undefined: lanes with a_vld[i]=0 hold their previous value; consumers must qualify with a_vld.

Test Plan:
- N1=4, M2=3, one tile, values 0x10+row*3+col, a_ready=1 -> over k=0..5, lane i carries row i's values at k=i..i+2; a_vld pattern 0001,0011,0111,1110,1100,1000; done pulses once.
- Two tiles back-to-back, M2=4 -> ready_A never drops; tile 2 starts streaming on the cycle after tile 1's k=6; zero idle gap.
- Three tiles, a_ready=0 for 20 cycles during tile 1 -> ready_A drops after tile 2's 16th address; outputs hold; no data lost; all 48 values correct in order.
- a_ready toggling 1/0 each cycle, M2=5 -> each k is presented for 2 cycles; sequence identical to the unstalled run.
- rst asserted mid-tile-2 at k=2 -> next cycle a_vld=0, a_out=0, ready_A=1, done=0; a fresh single tile afterwards streams correctly.
- A_ZERO_PAD_EN defined vs undefined, M2=2 -> invalid lanes read 0 vs hold the last value.

Source files
------------

// File: rtl/a_row_skew_feeder.sv
// a_row_skew_feeder: ping-pong N1xM2 A-tile buffer fed by BRAM reads (addr_vld_A/activate_A/last_addr_A/rd_data_A, credit ready_A) streamed to systolic rows with i-cycle skew (a_out/a_vld under a_ready, done after last tile); A_ZERO_PAD_EN zeroes invalid lanes
module a_row_skew_feeder #(
  parameter int N1 = 4,
  parameter int D_W = 8,
  parameter int MATRIXSIZE_W = 16,
  parameter int MAX_M2 = 64,
  parameter int RD_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [MATRIXSIZE_W-1:0] M2,
  input  logic                    addr_vld_A,
  input  logic [N1-1:0]           activate_A,
  input  logic                    last_addr_A,
  input  logic [D_W-1:0]          rd_data_A,
  output logic                    ready_A,
  output logic [N1*D_W-1:0]       a_out,
  output logic [N1-1:0]           a_vld,
  input  logic                    a_ready,
  output logic                    done
);
  localparam int CW = $clog2(MAX_M2);
  localparam int RW = $clog2(N1);
  localparam int KW = $clog2(MAX_M2 + N1);
  localparam int ICW = $clog2(N1 * MAX_M2 + 1);
  localparam int XW = MATRIXSIZE_W + 1;
  typedef enum logic [1:0] {EMPTY, LOADING, FULL, STREAMING} bank_t;
  typedef enum logic {IDLE, RUN} fsm_t;
  logic [D_W-1:0] mem [2][N1][MAX_M2];
  logic [RD_LAT-1:0] vld_d, last_d;
  logic [N1-1:0] act_d [RD_LAT];
  bank_t st [2];
  logic [1:0] tag;
  logic wb, ib, rb;
  logic [CW-1:0] wcol [N1];
  logic [ICW-1:0] ic, tile_m1;
  logic [KW-1:0] k;
  fsm_t fsm;
  logic [MATRIXSIZE_W-1:0] m2m1;
  logic [XW-1:0] klast;
  logic [RW-1:0] wrow;
  logic [N1-1:0] da, nv;
  logic [N1*D_W-1:0] nd;
  logic dv, dl, oh, we, wwrap, wfull, ic_wrap, ib_n, k_end;
  assign dv = vld_d[RD_LAT-1];
  assign dl = last_d[RD_LAT-1];
  assign da = act_d[RD_LAT-1];
  assign oh = (da != '0) && ((da & (da - N1'(1))) == '0);
  assign we = dv && oh;
  assign m2m1 = M2 - MATRIXSIZE_W'(1);
  assign wwrap = MATRIXSIZE_W'(wcol[wrow]) == m2m1;
  assign wfull = we && wrow == RW'(N1 - 1) && wwrap;
  assign tile_m1 = ICW'(N1 * M2 - 1);
  assign ic_wrap = addr_vld_A && ic == tile_m1;
  assign ib_n = ib ^ ic_wrap;
  assign klast = XW'(M2) + XW'(N1 - 2);
  assign k_end = XW'(k) == klast;
  always_comb begin
    wrow = '0;
    for (int i = 0; i < N1; i++) if (da[i]) wrow = RW'(i);
  end
  // Lane i shows row i delayed by i cycles: element k-i while that index is inside the row.
  always_comb begin
    nv = '0;
    nd = a_out;
    for (int i = 0; i < N1; i++) begin
      nv[i] = XW'(k) >= XW'(i) && XW'(k) < XW'(i) + XW'(M2);
`ifdef A_ZERO_PAD_EN
      nd[i*D_W +: D_W] = nv[i] ? mem[rb][i][CW'(k - KW'(i))] : '0;
`else
      nd[i*D_W +: D_W] = nv[i] ? mem[rb][i][CW'(k - KW'(i))] : a_out[i*D_W +: D_W];
`endif
    end
  end
  always_ff @(posedge clk) if (we) mem[wb][wrow][wcol[wrow]] <= rd_data_A;
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_d <= '0;
      last_d <= '0;
      for (int i = 0; i < RD_LAT; i++) act_d[i] <= '0;
      st[0] <= EMPTY;
      st[1] <= EMPTY;
      tag <= '0;
      wb <= 1'b0;
      ib <= 1'b0;
      rb <= 1'b0;
      for (int i = 0; i < N1; i++) wcol[i] <= '0;
      ic <= '0;
      ready_A <= 1'b1;
      fsm <= IDLE;
      k <= '0;
      a_out <= '0;
      a_vld <= '0;
      done <= 1'b0;
    end else begin
      vld_d[0] <= addr_vld_A;
      last_d[0] <= last_addr_A;
      act_d[0] <= activate_A;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_d[i] <= vld_d[i-1];
        last_d[i] <= last_d[i-1];
        act_d[i] <= act_d[i-1];
      end
      ic <= ic_wrap ? '0 : ic + ICW'(addr_vld_A);
      ib <= ib_n;
      // Credit looks one address ahead so upstream never targets an occupied bank.
      ready_A <= st[ib_n] == EMPTY || st[ib_n] == LOADING;
      done <= 1'b0;
      if (we) begin
        wcol[wrow] <= wwrap ? '0 : wcol[wrow] + CW'(1);
        if (st[wb] == EMPTY) st[wb] <= LOADING;
        if (wfull) begin
          st[wb] <= FULL;
          tag[wb] <= dl;
          wb <= ~wb;
          for (int i = 0; i < N1; i++) wcol[i] <= '0;
        end
      end
      if (fsm == IDLE) begin
        a_vld <= '0;
`ifdef A_ZERO_PAD_EN
        a_out <= '0;
`endif
        if (st[rb] == FULL) begin
          fsm <= RUN;
          st[rb] <= STREAMING;
          k <= '0;
        end
      end else if (a_ready) begin
        a_vld <= nv;
        a_out <= nd;
        k <= k + KW'(1);
        if (k_end) begin
          st[rb] <= EMPTY;
          rb <= ~rb;
          done <= tag[rb];
          k <= '0;
          if (st[~rb] == FULL) st[~rb] <= STREAMING;
          else fsm <= IDLE;
        end
      end
    end
  end
  a_onehot: assert property (@(posedge clk) disable iff (rst) dv |-> oh)
    else $error("a_row_skew_feeder: delayed activate_A not one-hot");
  a_no_overwrite: assert property (@(posedge clk) disable iff (rst) we |-> !(st[wb] inside {FULL, STREAMING}))
    else $error("a_row_skew_feeder: write into an occupied bank");
endmodule

// File: tb/tb_a_row_skew_feeder.sv
// tb_a_row_skew_feeder: scenario table plus reset sequence, checked against a per-tile skewed frame model
module tb_a_row_skew_feeder;
  localparam int N1 = 4, D_W = 8, MW = 16, MAX_M2 = 64, RD_LAT = 2;
  logic clk = 1'b0, rst = 1'b0;
  logic [MW-1:0] M2 = MW'(3);
  logic addr_vld_A = 1'b0, last_addr_A = 1'b0, a_ready = 1'b1;
  logic [N1-1:0] activate_A = '0;
  logic [D_W-1:0] rd_data_A = '0;
  logic ready_A, done;
  logic [N1*D_W-1:0] a_out;
  logic [N1-1:0] a_vld;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  a_row_skew_feeder #(.N1(N1), .D_W(D_W), .MATRIXSIZE_W(MW), .MAX_M2(MAX_M2), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .M2(M2), .addr_vld_A(addr_vld_A), .activate_A(activate_A),
    .last_addr_A(last_addr_A), .rd_data_A(rd_data_A), .ready_A(ready_A), .a_out(a_out),
    .a_vld(a_vld), .a_ready(a_ready), .done(done));
  typedef struct { logic [N1-1:0] vld; logic [N1*D_W-1:0] dat; bit last; bit tend; } frame_t;
  typedef struct { int m2; int tiles; int mode; int pat; int exp_frames; int exp_drop; } case_t;
  case_t tbl [8] = '{
    '{3, 1, 0, 0, 6, 0}, '{4, 2, 0, 1, 14, 0}, '{4, 3, 1, 1, 21, 1}, '{5, 2, 2, 1, 16, 2},
    '{2, 2, 0, 1, 10, 2}, '{1, 2, 0, 1, 8, 2}, '{64, 1, 3, 1, 67, 2}, '{7, 3, 3, 1, 30, 2}};
  frame_t fq[$];
  logic [D_W-1:0] iss_d[$];
  logic [N1-1:0] iss_a[$];
  bit iss_l[$];
  logic [N1-1:0] vseen[$];
  logic [D_W-1:0] hist [RD_LAT+1];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    addr_vld_A = 1'b0;
    activate_A = '0;
    last_addr_A = 1'b0;
    a_ready = 1'b1;
    tick();
    rst = 1'b0;
    for (int j = 0; j <= RD_LAT; j++) hist[j] = '0;
    rd_data_A = '0;
  endtask
  // Row-major issue order; each tile becomes M2+N1-1 frames where lane i holds row i, element k-i.
  task automatic build(input int m2, input int tiles, input int pat);
    logic [D_W-1:0] v [N1][MAX_M2];
    frame_t f;
    fq.delete(); iss_d.delete(); iss_a.delete(); iss_l.delete(); vseen.delete();
    for (int t = 0; t < tiles; t++) begin
      for (int r = 0; r < N1; r++)
        for (int c = 0; c < m2; c++) begin
          v[r][c] = pat != 0 ? D_W'($urandom) : D_W'(8'h10 + r * 3 + c);
          iss_d.push_back(v[r][c]);
          iss_a.push_back(N1'(1) << r);
          iss_l.push_back(t == tiles - 1 && r == N1 - 1 && c == m2 - 1);
        end
      for (int k = 0; k <= m2 + N1 - 2; k++) begin
        f.vld = '0;
        f.dat = '0;
        for (int i = 0; i < N1; i++)
          if (k >= i && k < i + m2) begin
            f.vld[i] = 1'b1;
            f.dat[i*D_W +: D_W] = v[i][k-i];
          end
        f.tend = k == m2 + N1 - 2;
        f.last = f.tend && t == tiles - 1;
        fq.push_back(f);
      end
    end
  endtask
  task automatic run(input int m2, input int mode, input int rst_at, output int pops, output bit drop);
    int cyc = 0, stall = 0;
    bit ar, prev_end = 1'b1, fin = 1'b0;
    logic [N1*D_W-1:0] prev_out;
    logic [N1-1:0] prev_vld;
    logic [D_W-1:0] nd;
    frame_t f;
    pops = 0;
    drop = 1'b0;
    M2 = MW'(m2);
    prev_out = a_out;
    prev_vld = a_vld;
    while (!fin) begin
      a_ready = mode == 1 ? stall == 0 : mode == 2 ? cyc % 2 == 0 : mode == 3 ? $urandom_range(0, 3) != 0 : 1'b1;
      if (stall > 0) stall--;
      if (!ready_A) drop = 1'b1;
      nd = '0;
      if (ready_A && iss_d.size() > 0 && (mode != 3 || $urandom_range(0, 2) != 0)) begin
        addr_vld_A = 1'b1;
        activate_A = iss_a.pop_front();
        last_addr_A = iss_l.pop_front();
        nd = iss_d.pop_front();
      end else begin
        addr_vld_A = 1'b0;
        activate_A = '0;
        last_addr_A = 1'b0;
      end
      for (int j = RD_LAT; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = nd;
      rd_data_A = hist[RD_LAT];
      ar = a_ready;
      tick();
      cyc++;
      if (ar && a_vld != '0) begin
        f = fq.pop_front();
        pops++;
        vseen.push_back(a_vld);
        chk("lane_vld", 64'(a_vld), 64'(f.vld));
        for (int i = 0; i < N1; i++)
`ifdef A_ZERO_PAD_EN
          chk("lane_data", 64'(a_out[i*D_W +: D_W]), f.vld[i] ? 64'(f.dat[i*D_W +: D_W]) : 64'(0));
`else
          chk("lane_data", 64'(a_out[i*D_W +: D_W]), f.vld[i] ? 64'(f.dat[i*D_W +: D_W]) : 64'(prev_out[i*D_W +: D_W]));
`endif
        chk("done", 64'(done), 64'(f.last));
        prev_end = f.tend;
        if (mode == 1 && pops == 1) stall = 20;
      end else begin
        chk("done_quiet", 64'(done), 64'(0));
        if (!ar && !prev_end) begin
          chk("hold_vld", 64'(a_vld), 64'(prev_vld));
          chk("hold_out", 64'(a_out), 64'(prev_out));
        end
      end
      prev_out = a_out;
      prev_vld = a_vld;
      if (rst_at >= 0 && pops == rst_at) begin
        do_reset();
        chk("rst_vld", 64'(a_vld), 64'(0));
        chk("rst_out", 64'(a_out), 64'(0));
        chk("rst_ready", 64'(ready_A), 64'(1));
        chk("rst_done", 64'(done), 64'(0));
        fq.delete(); iss_d.delete(); iss_a.delete(); iss_l.delete();
        fin = 1'b1;
      end else if (fq.size() == 0) begin
        fin = 1'b1;
        addr_vld_A = 1'b0;
        activate_A = '0;
        last_addr_A = 1'b0;
        a_ready = 1'b1;
        tick();
        chk("done_once", 64'(done), 64'(0));
        tick();
        chk("idle_vld", 64'(a_vld), 64'(0));
        chk("idle_ready", 64'(ready_A), 64'(1));
      end else if (cyc > 4000) begin
        errors++;
        checks++;
        $display("FAIL timeout: %0d frames outstanding, required 0", fq.size());
        fin = 1'b1;
      end
    end
  endtask
  initial begin
    int pops;
    bit drop;
    logic [N1-1:0] vpat [6] = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};
    for (int j = 0; j <= RD_LAT; j++) hist[j] = '0;
    do_reset();
    chk("reset_vld", 64'(a_vld), 64'(0));
    chk("reset_out", 64'(a_out), 64'(0));
    chk("reset_ready", 64'(ready_A), 64'(1));
    chk("reset_done", 64'(done), 64'(0));
    for (int c = 0; c < 8; c++) begin
      build(tbl[c].m2, tbl[c].tiles, tbl[c].pat);
      run(tbl[c].m2, tbl[c].mode, -1, pops, drop);
      chk("frames", 64'(pops), 64'(tbl[c].exp_frames));
      if (tbl[c].exp_drop != 2) chk("ready_drop", 64'(drop), 64'(tbl[c].exp_drop));
      if (c == 0)
        for (int j = 0; j < 6; j++) chk("skew_pattern", j < vseen.size() ? 64'(vseen[j]) : 64'hx, 64'(vpat[j]));
    end
    build(3, 2, 1);
    run(3, 0, 9, pops, drop);
    chk("frames_before_rst", 64'(pops), 64'(9));
    build(5, 1, 1);
    run(5, 0, -1, pops, drop);
    chk("frames_after_rst", 64'(pops), 64'(8));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
